// File: rtl/segre_mem_responder.sv
// rtl/segre_mem_responder.sv - single-request main-memory responder for MMU lane fills and stores
module segre_mem_responder #(
    parameter int ADDR_SIZE = 32,
    parameter int WORD_SIZE = 32,
    parameter int LANE_SIZE = 128,
    parameter int MEM_WORDS = 4096,
    parameter int LATENCY   = 4
) (
    input  logic                 clk_i,
    input  logic                 rsn_i,
    input  logic                 mem_req_i,
    input  logic                 mem_rd_i,
    input  logic                 mem_src_i,
    input  logic [ADDR_SIZE-1:0] mem_addr_i,
    input  logic [WORD_SIZE-1:0] mem_data_i,
    input  logic [1:0]           mem_data_type_i,
    output logic                 mem_ready_o,
    output logic                 mem_data_rdy_o,
    output logic [LANE_SIZE-1:0] mem_data_o,
    output logic                 mem_src_o
);

    localparam int IW = $clog2(MEM_WORDS);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam logic [1:0] BYTE = 2'd0;
    localparam logic [1:0] HALF = 2'd1;
    localparam logic [1:0] WORD = 2'd2;

    logic [1:0]           state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 rd_q, rd_d;
    logic                 src_q, src_d;
    logic [IW+1:0]        addr_q, addr_d;
    logic [WORD_SIZE-1:0] data_q, data_d;
    logic [1:0]           type_q, type_d;
    logic [LANE_SIZE-1:0] lane_q, lane_d;
    logic                 src_o_q, src_o_d;

    logic [WORD_SIZE-1:0] mem [MEM_WORDS];

    logic                 commit;
    logic                 wr_en;
    logic [IW-1:0]        word_idx;
    logic [WORD_SIZE-1:0] wr_word;
    logic                 unused_addr_bits;

    // Bits above the array span are dropped so addresses wrap.
    assign unused_addr_bits = ^mem_addr_i[ADDR_SIZE-1:IW+2];

    assign word_idx = addr_q[IW+1:2];
    assign commit   = (state_q == WAIT) && (cnt_q == '0);
    assign wr_en    = commit && !rd_q && (type_q != 2'd3);

    always_comb begin
        wr_word = mem[word_idx];
        case (type_q)
            BYTE:    wr_word[{addr_q[1:0], 3'b000} +: 8] = data_q[7:0];
            HALF:    wr_word[{addr_q[1], 4'b0000} +: 16] = data_q[15:0];
            WORD:    wr_word = data_q;
            default: wr_word = mem[word_idx];
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rd_d    = rd_q;
        src_d   = src_q;
        addr_d  = addr_q;
        data_d  = data_q;
        type_d  = type_q;
        lane_d  = lane_q;
        src_o_d = src_o_q;
        case (state_q)
            IDLE: begin
                if (mem_req_i) begin
                    state_d = WAIT;
                    cnt_d   = CW'(LATENCY - 1);
                    rd_d    = mem_rd_i;
                    src_d   = mem_src_i;
                    addr_d  = mem_addr_i[IW+1:0];
                    data_d  = mem_data_i;
                    type_d  = mem_data_type_i;
                end
            end
            WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    state_d = RESP;
                    src_o_d = src_q;
                    if (rd_q) begin
                        lane_d = {mem[{word_idx[IW-1:2], 2'd3}], mem[{word_idx[IW-1:2], 2'd2}],
                                  mem[{word_idx[IW-1:2], 2'd1}], mem[{word_idx[IW-1:2], 2'd0}]};
                    end
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rsn_i) begin
        if (!rsn_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rd_q    <= 1'b0;
            src_q   <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            type_q  <= 2'd0;
            lane_q  <= '0;
            src_o_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            src_q   <= src_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            type_q  <= type_d;
            lane_q  <= lane_d;
            src_o_q <= src_o_d;
        end
    end

    // Backing store is deliberately not reset.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem[word_idx] <= wr_word;
        end
    end

    assign mem_ready_o    = (state_q == IDLE);
    assign mem_data_rdy_o = (state_q == RESP);
    assign mem_data_o     = lane_q;
    assign mem_src_o      = src_o_q;

endmodule
